// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: classifies every cycle (memory wait, branch, load-use,
// jump, normal), drives stage enables/flushes, and keeps wait/stall/flush statistics.
module hazard_control_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs_i,
    input  logic [4:0]           id_rt_i,
    input  logic                 id_uses_rt_i,
    input  logic                 jmp_i,
    input  logic                 idex_mem_read_i,
    input  logic [4:0]           idex_rt_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_busy_i,
    output logic                 pc_enable_o,
    output logic                 ifid_enable_o,
    output logic                 idex_enable_o,
    output logic                 exmem_enable_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] flush_count_o,
    output logic                 dbg_state,
    output logic [2:0]           dbg_class
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CLS_RESET    = 3'd0,
        CLS_MEM_WAIT = 3'd1,
        CLS_BRANCH   = 3'd2,
        CLS_LOAD_USE = 3'd3,
        CLS_JUMP     = 3'd4,
        CLS_NORMAL   = 3'd5
    } cls_t;

    state_t              state;
    cls_t                cls;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                load_use;
    logic                stall_event;
    logic                flush_event;

    // A load into r0 never creates a dependency, so it is excluded here.
    always_comb begin
        load_use = 1'b0;
        if (idex_mem_read_i && (idex_rt_i != 5'd0)) begin
            load_use = (idex_rt_i == id_rs_i) ||
                       (id_uses_rt_i && (idex_rt_i == id_rt_i));
        end
    end

    always_comb begin
        cls = CLS_NORMAL;
        if (reset) begin
            cls = CLS_RESET;
        end else if (mem_busy_i) begin
            cls = CLS_MEM_WAIT;
        end else if (branch_taken_i) begin
            cls = CLS_BRANCH;
        end else if (load_use) begin
            cls = CLS_LOAD_USE;
        end else if (jmp_i) begin
            cls = CLS_JUMP;
        end
    end

    // While loads stall, IF/ID holds the jump so it is simply re-seen next cycle.
    always_comb begin
        pc_enable_o    = 1'b1;
        ifid_enable_o  = 1'b1;
        idex_enable_o  = 1'b1;
        exmem_enable_o = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        case (cls)
            CLS_RESET: begin
                pc_enable_o    = 1'b0;
                ifid_enable_o  = 1'b0;
                idex_enable_o  = 1'b0;
                exmem_enable_o = 1'b0;
                ifid_flush_o   = 1'b1;
                idex_flush_o   = 1'b1;
            end
            CLS_MEM_WAIT: begin
                pc_enable_o    = 1'b0;
                ifid_enable_o  = 1'b0;
                idex_enable_o  = 1'b0;
                exmem_enable_o = 1'b0;
            end
            CLS_BRANCH: begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end
            CLS_LOAD_USE: begin
                pc_enable_o   = 1'b0;
                ifid_enable_o = 1'b0;
                idex_flush_o  = 1'b1;
            end
            CLS_JUMP: begin
                ifid_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The first busy cycle seen from RUN always counts as one wait cycle.
    always_comb begin
        wait_next = WAIT_W'(1);
        if (state == MEM_WAIT) begin
            wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    assign stall_event = (cls == CLS_MEM_WAIT) || (cls == CLS_LOAD_USE);
    assign flush_event = (cls == CLS_BRANCH) || (cls == CLS_JUMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            wait_cnt       <= '0;
            timeout_o      <= 1'b0;
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (mem_busy_i) begin
                state    <= MEM_WAIT;
                wait_cnt <= wait_next;
                if (wait_next == WAIT_MAX) begin
                    timeout_o <= 1'b1;
                end
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
            if (stall_event && (stall_cycles_o != CNT_MAX)) begin
                stall_cycles_o <= stall_cycles_o + 1'b1;
            end
            if (flush_event && (flush_count_o != CNT_MAX)) begin
                flush_count_o <= flush_count_o + 1'b1;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_class = cls;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: table vectors, corner sequences and random traffic
// checked against a rule-level model, on a default instance and a small-parameter one.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       rst;
    logic       busy;
    logic       br;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       jmp;
  } vec_t;

  typedef struct packed {
    vec_t       in;
    logic [5:0] exp;  // {pc, ifid, idex, exmem, ifid_flush, idex_flush}
  } tv_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic id_uses_rt = 1'b0, jmp = 1'b0, idex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

  logic a_pc, a_ifid, a_idex, a_exmem, a_iff, a_xf, a_to, a_dst;
  logic [15:0] a_stall, a_flush;
  logic [2:0] a_dcls;
  logic b_pc, b_ifid, b_idex, b_exmem, b_iff, b_xf, b_to, b_dst;
  logic [3:0] b_stall, b_flush;
  logic [2:0] b_dcls;

  int checks = 0;
  int errors = 0;

  int t_lim[2] = '{255, 4};
  int c_max[2] = '{65535, 15};
  int m_wait[2];
  int m_to[2];
  int m_stall[2];
  int m_flush[2];

  tv_t tbl[10];

  hazard_control_unit dut_a (
    .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .jmp_i(jmp), .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
    .pc_enable_o(a_pc), .ifid_enable_o(a_ifid), .idex_enable_o(a_idex), .exmem_enable_o(a_exmem),
    .ifid_flush_o(a_iff), .idex_flush_o(a_xf), .timeout_o(a_to),
    .stall_cycles_o(a_stall), .flush_count_o(a_flush), .dbg_state(a_dst), .dbg_class(a_dcls)
  );

  hazard_control_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .jmp_i(jmp), .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
    .pc_enable_o(b_pc), .ifid_enable_o(b_ifid), .idex_enable_o(b_idex), .exmem_enable_o(b_exmem),
    .ifid_flush_o(b_iff), .idex_flush_o(b_xf), .timeout_o(b_to),
    .stall_cycles_o(b_stall), .flush_count_o(b_flush), .dbg_state(b_dst), .dbg_class(b_dcls)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_load_use(input vec_t v);
    return v.mr && (v.ex_rt != 5'd0) && ((v.ex_rt == v.rs) || (v.uses && (v.ex_rt == v.rt)));
  endfunction

  function automatic logic [5:0] ref_comb(input vec_t v);
    if (v.rst) return 6'b0000_11;
    if (v.busy) return 6'b0000_00;
    if (v.br) return 6'b1111_11;
    if (is_load_use(v)) return 6'b0011_01;
    if (v.jmp) return 6'b1111_10;
    return 6'b1111_00;
  endfunction

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_update(input vec_t v);
    logic lu;
    lu = is_load_use(v);
    for (int k = 0; k < 2; k++) begin
      if (v.rst) begin
        m_wait[k] = 0;
        m_to[k] = 0;
        m_stall[k] = 0;
        m_flush[k] = 0;
      end else begin
        if (v.busy) begin
          m_wait[k] = sat(m_wait[k] + 1, t_lim[k]);
          if (m_wait[k] == t_lim[k]) m_to[k] = 1;
        end else begin
          m_wait[k] = 0;
        end
        if (v.busy || (!v.br && lu)) m_stall[k] = sat(m_stall[k] + 1, c_max[k]);
        if (!v.busy && (v.br || (!lu && v.jmp))) m_flush[k] = sat(m_flush[k] + 1, c_max[k]);
      end
    end
  endtask

  // driver: applies one cycle of inputs, checks everything against the model, then advances it
  task automatic apply(input vec_t v);
    logic [5:0] e;
    @(negedge clk);
    reset = v.rst;
    mem_busy = v.busy;
    branch_taken = v.br;
    idex_mem_read = v.mr;
    idex_rt = v.ex_rt;
    id_rs = v.rs;
    id_rt = v.rt;
    id_uses_rt = v.uses;
    jmp = v.jmp;
    #1;
    e = ref_comb(v);
    chk("a_comb", {a_pc, a_ifid, a_idex, a_exmem, a_iff, a_xf}, e);
    chk("b_comb", {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_xf}, e);
    chk("a_timeout", a_to, m_to[0]);
    chk("b_timeout", b_to, m_to[1]);
    chk("a_stall", a_stall, m_stall[0]);
    chk("b_stall", b_stall, m_stall[1]);
    chk("a_flush", a_flush, m_flush[0]);
    chk("b_flush", b_flush, m_flush[1]);
    model_update(v);
  endtask

  function automatic vec_t mk(input logic rst, input logic busy, input logic br, input logic mr,
                              input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic j);
    vec_t v;
    v.rst = rst; v.busy = busy; v.br = br; v.mr = mr; v.ex_rt = ex_rt;
    v.rs = rs; v.rt = rt; v.uses = uses; v.jmp = j;
    return v;
  endfunction

  task automatic do_reset();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vec_t v;
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end

    tbl[0] = '{in: mk(0, 0, 0, 0, 0, 0, 0, 0, 0),   exp: 6'b1111_00};
    tbl[1] = '{in: mk(0, 0, 0, 1, 5, 5, 0, 0, 0),   exp: 6'b0011_01};
    tbl[2] = '{in: mk(0, 0, 0, 1, 0, 0, 0, 1, 0),   exp: 6'b1111_00};
    tbl[3] = '{in: mk(0, 0, 0, 1, 7, 3, 7, 1, 0),   exp: 6'b0011_01};
    tbl[4] = '{in: mk(0, 0, 0, 1, 7, 3, 7, 0, 0),   exp: 6'b1111_00};
    tbl[5] = '{in: mk(0, 0, 1, 1, 5, 5, 0, 0, 1),   exp: 6'b1111_11};
    tbl[6] = '{in: mk(0, 0, 0, 0, 0, 0, 0, 0, 1),   exp: 6'b1111_10};
    tbl[7] = '{in: mk(0, 0, 0, 1, 9, 9, 0, 0, 1),   exp: 6'b0011_01};
    tbl[8] = '{in: mk(0, 0, 0, 0, 5, 5, 5, 1, 0),   exp: 6'b1111_00};
    tbl[9] = '{in: mk(0, 1, 1, 1, 5, 5, 0, 0, 1),   exp: 6'b0000_00};

    // reset state
    do_reset();
    chk("reset_enables", {a_pc, a_ifid, a_idex, a_exmem}, 4'b0000);
    chk("reset_flushes", {a_iff, a_xf}, 2'b11);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d_a", i), {a_pc, a_ifid, a_idex, a_exmem, a_iff, a_xf}, tbl[i].exp);
      chk($sformatf("tbl%0d_b", i), {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_xf}, tbl[i].exp);
    end

    // single load-use stall counts once
    do_reset();
    apply(mk(0, 0, 0, 1, 5, 5, 0, 0, 0));
    idle();
    chk("lu_stall_1", a_stall, 1);

    // load into r0 is not a hazard
    do_reset();
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    idle();
    chk("r0_no_stall", a_stall, 0);

    // branch overrides load-use and jump
    do_reset();
    apply(mk(0, 0, 1, 1, 5, 5, 0, 0, 1));
    idle();
    chk("br_flush_1", a_flush, 1);
    chk("br_stall_0", a_stall, 0);

    // three memory-wait cycles then resume
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("mw_enables", {a_pc, a_ifid, a_idex, a_exmem}, 4'b0000);
    end
    idle();
    chk("mw_resume", {a_pc, a_ifid, a_idex, a_exmem}, 4'b1111);
    chk("mw_stall_3", a_stall, 3);
    chk("mw_timeout_0", a_to, 0);
    chk("mw_b_timeout_0", b_to, 0);

    // timeout on the small instance, then reset from MEM_WAIT with timeout set
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      chk($sformatf("to_seq%0d", i), b_to, (i - 1 >= 4) ? 1 : 0);
    end
    do_reset();
    idle();
    chk("to_cleared", b_to, 0);
    chk("to_stall_cleared", b_stall, 0);
    chk("to_flush_cleared", b_flush, 0);
    chk("to_run_normal", {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_xf}, 6'b1111_00);

    // stall counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++) apply(mk(0, 0, 0, 1, 3, 3, 0, 0, 0));
    idle();
    chk("sat_stall_15", b_stall, 15);
    chk("sat_a_stall_16", a_stall, 16);
    for (int i = 0; i < 17; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    idle();
    chk("sat_flush_15", b_flush, 15);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v.rst = ($urandom_range(0, 60) == 0);
      v.busy = ($urandom_range(0, 3) == 0);
      v.br = ($urandom_range(0, 5) == 0);
      v.mr = $urandom_range(0, 1);
      v.ex_rt = 5'($urandom_range(0, 3));
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.uses = $urandom_range(0, 1);
      v.jmp = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) begin
        for (int j = 0; j < 7; j++) begin
          v.busy = 1'b1;
          v.rst = 1'b0;
          apply(v);
        end
      end else begin
        apply(v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
